// File: rtl/lfsr_count_ctrl.sv
// Searches an XNOR Fibonacci LFSR sequence for a target value, counting shifts until hit or timeout.
// Optional macro LFSR_HOLD_EN adds a 'hold' input that freezes the search while in RUN.
module lfsr_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
`ifdef LFSR_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] lfsr_q,
  output logic [WIDTH-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic             hit
);

  if (WIDTH < 4 || WIDTH > 8) begin : g_bad_width
    $error("lfsr_count_ctrl: WIDTH must be in 4..8");
  end

  // Tap positions per width, chosen so the XNOR form runs maximal length.
  localparam logic [7:0] TAP_MASK =
    (WIDTH == 4) ? 8'b0000_1100 :
    (WIDTH == 5) ? 8'b0001_0100 :
    (WIDTH == 6) ? 8'b0011_0000 :
    (WIDTH == 7) ? 8'b0110_0000 :
                   8'b1011_1000;

  // Last reachable step count: 2^WIDTH-1 states, so at most 2^WIDTH-2 shifts.
  localparam logic [WIDTH-1:0] MAX_STEPS = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] seed_cap;
  logic [WIDTH-1:0] target_cap;
  logic             match;
  logic             timeout;
  logic             fb;
  logic             freeze;

  assign match   = &(lfsr_q ~^ target_cap);
  assign timeout = (steps == MAX_STEPS);
  assign fb      = ~^(lfsr_q & TAP_MASK[WIDTH-1:0]);

`ifdef LFSR_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seed_cap   <= '0;
      target_cap <= '0;
      lfsr_q     <= '0;
      steps      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_cap   <= seed;
            target_cap <= target;
            steps      <= '0;
            hit        <= 1'b0;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        // The all-ones word is the XNOR lockup state, so it is never loaded.
        LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            hit   <= 1'b0;
            state <= IDLE;
          end else begin
            lfsr_q <= (seed_cap == ALL_ONES) ? '0 : seed_cap;
            state  <= RUN;
          end
        end
        // Abort wins over hold, match and timeout; hold wins over match and timeout.
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            hit   <= 1'b0;
            state <= IDLE;
          end else if (!freeze) begin
            if (match || timeout) begin
              hit   <= match;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              lfsr_q <= {lfsr_q[WIDTH-2:0], fb};
              steps  <= steps + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_count_ctrl.sv
// Randomized bench for lfsr_count_ctrl: a timeline model built from the LFSR sequence is compared every cycle.
// Define LFSR_HOLD_EN to also exercise the hold input.
module tb_lfsr_count_ctrl;

  localparam int W    = 4;
  localparam int ALL1 = (1 << W) - 1;
  localparam int MAXS = (1 << W) - 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         hold;
  logic [W-1:0] seed;
  logic [W-1:0] target;
  logic [W-1:0] lfsr_q;
  logic [W-1:0] steps;
  logic         busy;
  logic         done;
  logic         hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_count_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
`ifdef LFSR_HOLD_EN
    .hold   (hold),
`endif
    .seed   (seed),
    .target (target),
    .lfsr_q (lfsr_q),
    .steps  (steps),
    .busy   (busy),
    .done   (done),
    .hit    (hit)
  );

  typedef struct {
    logic [W-1:0] lfsr;
    logic [W-1:0] steps;
    logic         busy;
    logic         done;
    logic         hit;
  } exp_t;

  exp_t exp_q[$];

  // Current search as seen by the model: the visited sequence and the phase lengths.
  int cur_seq[0:MAXS];
  int cur_k;
  bit cur_hit;
  int cur_r;
  int cur_a;
  int cur_hat;
  int cur_hlen;
  int prev_l;
  int obs_done_edge;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // XNOR of taps {3,2}, shifted in at the bottom.
  function automatic int lfsrStep(input int v);
    int fb;
    fb = 1 ^ ((v >> 3) & 1) ^ ((v >> 2) & 1);
    return ((v << 1) | fb) & ALL1;
  endfunction

  // Expected outputs c cycles after the edge that accepted start (c=0 is the load cycle).
  function automatic exp_t expAt(input int c);
    exp_t e;
    int   eff;
    bit   ab;
    int   r;
    int   held;
    int   j;
    ab  = (cur_a >= 0) && (c > cur_a);
    eff = ab ? cur_a : c;
    if (eff == 0) begin
      e.lfsr  = W'(prev_l);
      e.steps = '0;
    end else if (eff <= cur_r) begin
      r    = eff - 1;
      held = r - cur_hat;
      if (held < 0) held = 0;
      if (held > cur_hlen) held = cur_hlen;
      j       = r - held;
      e.lfsr  = W'(cur_seq[j]);
      e.steps = W'(j);
    end else begin
      e.lfsr  = W'(cur_seq[cur_k]);
      e.steps = W'(cur_k);
    end
    e.busy = !ab && (eff <= cur_r);
    e.done = !ab && (c == cur_r + 1);
    e.hit  = !ab && (c > cur_r) && cur_hit;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("lfsr_q", lfsr_q, e.lfsr);
      checkOutput("steps",  steps,  e.steps);
      checkOutput("busy",   busy,   e.busy);
      checkOutput("done",   done,   e.done);
      checkOutput("hit",    hit,    e.hit);
    end
  end

  // One search: a<0 means no abort, otherwise abort in cycle a; hold for hlen run cycles from run cycle hat.
  task automatic applyStimulus(input int s, input int t, input int a, input int hat, input int hlen);
    int v;
    int last_c;
    int busy_end;
    bit window;
    v = (s == ALL1) ? 0 : s;
    for (int i = 0; i <= MAXS; i++) begin
      cur_seq[i] = v;
      v = lfsrStep(v);
    end
    cur_k   = MAXS;
    cur_hit = 1'b0;
    for (int i = 0; i <= MAXS; i++) begin
      if (cur_seq[i] == t) begin
        cur_k   = i;
        cur_hit = 1'b1;
        break;
      end
    end
`ifndef LFSR_HOLD_EN
    hlen = 0;
`endif
    if (hat > cur_k) hat = cur_k;
    cur_hat  = hat;
    cur_hlen = hlen;
    cur_r    = cur_k + 1 + hlen;
    if (a > cur_r) a = cur_r;
    cur_a    = a;
    busy_end = (a >= 0) ? a : cur_r;
    last_c   = busy_end + 3;
    obs_done_edge = -1;
    start  = 1'b1;
    seed   = W'(s);
    target = W'(t);
    abort  = 1'b0;
    hold   = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) obs_done_edge = c + 1;
      exp_q.push_back(expAt(c));
      start  = (c <= busy_end + ((a >= 0) ? 0 : 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      seed   = W'($urandom);
      target = W'($urandom);
      abort  = (c == a) ? 1'b1 : ((c > busy_end) ? 1'($urandom_range(0, 1)) : 1'b0);
      window = (c >= 1) && (c - 1 >= hat) && (c - 1 < hat + hlen);
      hold   = window || ((c == 0 || c > busy_end) && ($urandom_range(0, 1) == 1));
    end
    prev_l = int'(expAt(last_c).lfsr);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    hold   = 1'b0;
    seed   = '0;
    target = '0;
    prev_l = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_lfsr",  lfsr_q, 0);
    checkOutput("reset_steps", steps,  0);
    checkOutput("reset_busy",  busy,   0);
    checkOutput("reset_done",  done,   0);
    checkOutput("reset_hit",   hit,    0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pinned scenarios with hand-computed outcomes.
    applyStimulus(4'b0000, 4'b0111, -1, 0, 0);
    checkOutput("seq_steps",   steps, 3);
    checkOutput("seq_hit",     hit, 1);
    checkOutput("seq_lfsr",    lfsr_q, 4'b0111);
    checkOutput("seq_done_at", obs_done_edge, 6);

    applyStimulus(4'b0101, 4'b0101, -1, 0, 0);
    checkOutput("same_steps",   steps, 0);
    checkOutput("same_hit",     hit, 1);
    checkOutput("same_done_at", obs_done_edge, 3);

    applyStimulus(4'b0000, 4'b1111, -1, 0, 0);
    checkOutput("tmo_steps",   steps, 14);
    checkOutput("tmo_hit",     hit, 0);
    checkOutput("tmo_done_at", obs_done_edge, 17);

    applyStimulus(4'b1111, 4'b0000, -1, 0, 0);
    checkOutput("lock_lfsr",  lfsr_q, 0);
    checkOutput("lock_steps", steps, 0);
    checkOutput("lock_hit",   hit, 1);

    applyStimulus(4'b0000, 4'b0111, 3, 0, 0);
    checkOutput("abort_steps", steps, 2);
    checkOutput("abort_hit",   hit, 0);
    checkOutput("abort_busy",  busy, 0);
    checkOutput("abort_nodone", obs_done_edge, -1);

    applyStimulus(4'b0001, 4'b0011, -1, 0, 0);
    checkOutput("after_abort_hit",   hit, 1);
    checkOutput("after_abort_steps", steps, 1);

`ifdef LFSR_HOLD_EN
    applyStimulus(4'b0000, 4'b0111, -1, 1, 3);
    checkOutput("hold_done_at", obs_done_edge, 9);
    checkOutput("hold_steps",   steps, 3);
`endif

    // Asynchronous reset in the middle of a long search.
    start  = 1'b1;
    seed   = 4'b0000;
    target = 4'b1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_lfsr",  lfsr_q, 0);
    checkOutput("arst_steps", steps,  0);
    checkOutput("arst_busy",  busy,   0);
    checkOutput("arst_done",  done,   0);
    checkOutput("arst_hit",   hit,    0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    prev_l = 0;
    @(posedge clk);
    #1;
    applyStimulus(4'b0110, 4'b0110, -1, 0, 0);
    checkOutput("fresh_hit",     hit, 1);
    checkOutput("fresh_done_at", obs_done_edge, 3);

    // Random searches, some with aborts and holds.
    for (int n = 0; n < 40; n++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
      applyStimulus(int'($urandom_range(0, ALL1)), int'($urandom_range(0, ALL1)), a,
                    int'($urandom_range(0, 14)), int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
